// File: rtl/cache_req_extractor.sv
// AXI AR/AW arbiter feeding the DRAM-cache request FIFO through a one-entry output register.
// Handshake at N -> push at N+1 earliest; fifo_afull_i holds the entry, and ready drops while it is held.
module cache_req_extractor #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 16,
    parameter int INDEX_BITS = 4,
    parameter int INDEX_LSB  = 6,
    parameter int PRIO_MODE  = 0,
    parameter int CNT_WIDTH  = 32,
    localparam int ENTRY_W   = 1 + ID_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ID_WIDTH-1:0]   awid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    output logic [INDEX_BITS-1:0] index_o,
    input  logic                  fifo_afull_i,
    output logic                  fifo_write_en_o,
    output logic [ENTRY_W-1:0]    fifo_data_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]   id;
        logic                  is_write;
    } entry_t;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t                r_state;
    entry_t                r_entry;
    logic [INDEX_BITS-1:0] r_index;
    logic                  r_last_aw;
    logic [CNT_WIDTH-1:0]  r_rd_cnt;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;

    logic   w_out_vld;
    logic   w_push;
    logic   w_can_accept;
    logic   w_grant_ar;
    logic   w_grant_aw;
    logic   w_ar_hs;
    logic   w_aw_hs;
    logic   w_hs;
    entry_t w_sel;

    // Gating with rst_n keeps ready and push low during the reset cycle itself.
    assign w_out_vld    = (r_state == S_FULL);
    assign w_push       = rst_n & w_out_vld & ~fifo_afull_i;
    assign w_can_accept = rst_n & (~w_out_vld | w_push);

    assign w_grant_ar = arvalid_i & (~awvalid_i | (PRIO_MODE != 0) | r_last_aw);
    assign w_grant_aw = awvalid_i & ~w_grant_ar;

    assign arready_o = w_can_accept & w_grant_ar;
    assign awready_o = w_can_accept & w_grant_aw;
    assign w_ar_hs   = arvalid_i & arready_o;
    assign w_aw_hs   = awvalid_i & awready_o;
    assign w_hs      = w_ar_hs | w_aw_hs;

    always_comb begin
        w_sel.is_write = w_grant_aw;
        w_sel.id       = w_grant_aw ? awid_i   : arid_i;
        w_sel.addr     = w_grant_aw ? awaddr_i : araddr_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_entry   <= '0;
            r_index   <= '0;
            r_last_aw <= 1'b1;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_hs) r_state <= S_FULL;
                S_FULL:  if (w_push && !w_hs) r_state <= S_EMPTY;
            endcase
            if (w_hs) begin
                r_entry   <= w_sel;
                r_index   <= w_sel.addr[INDEX_LSB +: INDEX_BITS];
                r_last_aw <= w_grant_aw;
            end
            if (w_ar_hs && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            if (w_aw_hs && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
        end
    end

    assign fifo_write_en_o = w_push;
    assign fifo_data_o     = r_entry;
    assign index_o         = r_index;
    assign rd_cnt_o        = r_rd_cnt;
    assign wr_cnt_o        = r_wr_cnt;

endmodule

// File: tb/tb_cache_req_extractor.sv
// Bench for cache_req_extractor: round-robin/32-bit-counter instance A, AR-priority/3-bit-counter instance B.
module tb_cache_req_extractor;

    localparam int AW = 64;
    localparam int IW = 16;
    localparam int IB = 4;
    localparam int IL = 6;
    localparam int EW = 1 + IW + AW;

    typedef struct {
        logic [EW-1:0] dat;
        logic [IB-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] arid, awid;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid_a, awvalid_a, arvalid_b, awvalid_b;
    logic          afull;

    logic          a_arready, a_awready, a_we;
    logic [IB-1:0] a_idx;
    logic [EW-1:0] a_data;
    logic [31:0]   a_rd, a_wr;
    logic          b_arready, b_awready, b_we;
    logic [IB-1:0] b_idx;
    logic [EW-1:0] b_data;
    logic [2:0]    b_rd, b_wr;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cache_req_extractor #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .INDEX_BITS(IB), .INDEX_LSB(IL),
                          .PRIO_MODE(0), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid_a), .arready_o(a_arready),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid_a), .awready_o(a_awready),
        .index_o(a_idx), .fifo_afull_i(afull), .fifo_write_en_o(a_we), .fifo_data_o(a_data),
        .rd_cnt_o(a_rd), .wr_cnt_o(a_wr)
    );

    cache_req_extractor #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .INDEX_BITS(IB), .INDEX_LSB(IL),
                          .PRIO_MODE(1), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid_b), .arready_o(b_arready),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid_b), .awready_o(b_awready),
        .index_o(b_idx), .fifo_afull_i(afull), .fifo_write_en_o(b_we), .fifo_data_o(b_data),
        .rd_cnt_o(b_rd), .wr_cnt_o(b_wr)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_wr, input logic [IW-1:0] id, input logic [AW-1:0] addr);
        exp_t e;
        e.dat = {addr, id, is_wr};
        e.idx = addr[IL +: IB];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arvalid_a = 1'b0; awvalid_a = 1'b0; arvalid_b = 1'b0; awvalid_b = 1'b0;
        afull = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (a_we) begin
            check("a_push_expected", 128'(qa.size() != 0), 128'd1);
            if (qa.size() != 0) begin
                exp_t e;
                e = qa.pop_front();
                check("a_push_dat", 128'(a_data), 128'(e.dat));
                check("a_push_idx", 128'(a_idx), 128'(e.idx));
            end
        end
        if (b_we) begin
            check("b_push_expected", 128'(qb.size() != 0), 128'd1);
            if (qb.size() != 0) begin
                exp_t e;
                e = qb.pop_front();
                check("b_push_dat", 128'(b_data), 128'(e.dat));
                check("b_push_idx", 128'(b_idx), 128'(e.idx));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        arid = '0; awid = '0; araddr = '0; awaddr = '0;
        arvalid_a = 1'b1; awvalid_a = 1'b0; arvalid_b = 1'b0; awvalid_b = 1'b0;
        afull = 1'b0;

        // Reset values, with a request already presented on AR.
        @(negedge clk);
        check("rst_arready", 128'(a_arready), 128'd0);
        check("rst_awready", 128'(a_awready), 128'd0);
        check("rst_we",      128'(a_we), 128'd0);
        check("rst_data",    128'(a_data), 128'd0);
        check("rst_idx",     128'(a_idx), 128'd0);
        check("rst_rdcnt",   128'(a_rd), 128'd0);
        check("rst_wrcnt",   128'(a_wr), 128'd0);
        arvalid_a = 1'b0;
        step();
        rst_n = 1'b1;

        // Single read.
        araddr = 64'h0000_0000_0000_1A40; arid = 16'h0005; arvalid_a = 1'b1;
        qa.push_back(mk(1'b0, arid, araddr));
        @(negedge clk);
        check("t1_arready", 128'(a_arready), 128'd1);
        check("t1_we_early", 128'(a_we), 128'd0);
        step();
        arvalid_a = 1'b0;
        @(negedge clk);
        check("t1_we", 128'(a_we), 128'd1);
        check("t1_idx", 128'(a_idx), 128'h9);
        check("t1_rdcnt", 128'(a_rd), 128'd1);
        step();
        check("t1_we_once", 128'(a_we), 128'd0);

        // Round-robin with both channels held valid.
        do_reset();
        araddr = 64'h0000_0000_DEAD_0080; arid = 16'h0011;
        awaddr = 64'h1234_5678_0000_03C0; awid = 16'h0022;
        arvalid_a = 1'b1; awvalid_a = 1'b1;
        for (int k = 0; k < 4; k++)
            qa.push_back(mk(k[0], k[0] ? awid : arid, k[0] ? awaddr : araddr));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_arready", 128'(a_arready), 128'(k % 2 == 0));
            check("rr_awready", 128'(a_awready), 128'(k % 2 == 1));
            check("rr_we", 128'(a_we), 128'(k != 0));
            step();
        end
        arvalid_a = 1'b0; awvalid_a = 1'b0;
        @(negedge clk);
        check("rr_we_last", 128'(a_we), 128'd1);
        check("rr_rdcnt", 128'(a_rd), 128'd2);
        check("rr_wrcnt", 128'(a_wr), 128'd2);
        step();

        // Back-pressure with a second request pending.
        awaddr = 64'h0000_0000_0000_0540; awid = 16'h0033; awvalid_a = 1'b1;
        qa.push_back(mk(1'b1, awid, awaddr));
        @(negedge clk);
        check("bp_awready", 128'(a_awready), 128'd1);
        step();
        awvalid_a = 1'b0; afull = 1'b1;
        araddr = 64'hFFFF_0000_0000_01C0; arid = 16'h0044; arvalid_a = 1'b1;
        qa.push_back(mk(1'b0, arid, araddr));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_we_held", 128'(a_we), 128'd0);
            check("bp_arready_held", 128'(a_arready), 128'd0);
            check("bp_data_stable", 128'(a_data), 128'({64'h0000_0000_0000_0540, 16'h0033, 1'b1}));
            step();
        end
        afull = 1'b0;
        @(negedge clk);
        check("bp_we_release", 128'(a_we), 128'd1);
        check("bp_arready_release", 128'(a_arready), 128'd1);
        step();
        arvalid_a = 1'b0;
        @(negedge clk);
        check("bp_we_next", 128'(a_we), 128'd1);
        step();

        // Reset while an entry is held.
        awaddr = 64'h0000_0000_0000_0F00; awid = 16'h0055; awvalid_a = 1'b1;
        @(negedge clk);
        check("mr_awready", 128'(a_awready), 128'd1);
        step();
        awvalid_a = 1'b0; afull = 1'b1;
        @(negedge clk);
        check("mr_we_held", 128'(a_we), 128'd0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_we_in_rst", 128'(a_we), 128'd0);
        step();
        rst_n = 1'b1; afull = 1'b0;
        @(negedge clk);
        check("mr_we_after", 128'(a_we), 128'd0);
        check("mr_rdcnt", 128'(a_rd), 128'd0);
        check("mr_wrcnt", 128'(a_wr), 128'd0);
        check("mr_data", 128'(a_data), 128'd0);
        step();
        araddr = 64'h0000_0000_0000_02C0; arid = 16'h0066;
        awaddr = 64'h0000_0000_0000_0300; awid = 16'h0077;
        arvalid_a = 1'b1; awvalid_a = 1'b1;
        qa.push_back(mk(1'b0, arid, araddr));
        qa.push_back(mk(1'b1, awid, awaddr));
        @(negedge clk);
        check("mr_tie_ar", 128'(a_arready), 128'd1);
        check("mr_tie_aw", 128'(a_awready), 128'd0);
        step();
        arvalid_a = 1'b0;
        @(negedge clk);
        check("mr_aw_pending_ok", 128'(a_awready), 128'd1);
        step();
        awvalid_a = 1'b0;
        @(negedge clk);
        check("mr_we_aw", 128'(a_we), 128'd1);
        step();

        // Read strict priority on instance B.
        do_reset();
        araddr = 64'h0000_0000_0000_0A80; arid = 16'h0088;
        awaddr = 64'h0000_0000_0000_0D00; awid = 16'h0099;
        arvalid_b = 1'b1; awvalid_b = 1'b1;
        for (int k = 0; k < 3; k++) qb.push_back(mk(1'b0, arid, araddr));
        qb.push_back(mk(1'b1, awid, awaddr));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pr_arready", 128'(b_arready), 128'd1);
            check("pr_awready", 128'(b_awready), 128'd0);
            step();
        end
        arvalid_b = 1'b0;
        @(negedge clk);
        check("pr_awready_after", 128'(b_awready), 128'd1);
        step();
        awvalid_b = 1'b0;
        @(negedge clk);
        check("pr_rdcnt", 128'(b_rd), 128'd3);
        check("pr_wrcnt", 128'(b_wr), 128'd1);
        step();

        // Counter saturation on the 3-bit instance.
        do_reset();
        arvalid_b = 1'b1;
        for (int k = 0; k < 9; k++) qb.push_back(mk(1'b0, arid, araddr));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("sat_rdcnt", 128'(b_rd), 128'((k > 7) ? 7 : k));
            check("sat_arready", 128'(b_arready), 128'd1);
            step();
        end
        arvalid_b = 1'b0;
        @(negedge clk);
        check("sat_rdcnt_final", 128'(b_rd), 128'd7);
        step();
        step();

        check("qa_drained", 128'(qa.size()), 128'd0);
        check("qb_drained", 128'(qb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_req_extractor.md
Name: cache_req_extractor

Overview:
- Parametrised front end of the DRAM-cache request path.
- Accepts AXI read-address (AR) and write-address (AW) requests with a proper valid/ready handshake.
- Arbitrates between them in round-robin or read-priority mode, and extracts the cache set index from a configurable address bit range.
- Pushes a packed request entry into the downstream request FIFO through a one-entry output register, honouring FIFO almost-full back-pressure, and keeps saturating read/write request counters.

Parameters:
ADDR_WIDTH, 64, AXI address width
ID_WIDTH, 16, AXI ID width
INDEX_BITS, 4, cache set-index width (>=1)
INDEX_LSB, 6, LSB position of index in address (line-offset bits); INDEX_LSB+INDEX_BITS <= ADDR_WIDTH
PRIO_MODE, 0, 0 = round-robin AR/AW, 1 = AR strict priority
CNT_WIDTH, 32, width of request counters
ENTRY_W, 1+ID_WIDTH+ADDR_WIDTH, derived (localparam) FIFO entry width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
arid_i  in  ID_WIDTH  AR ID
araddr_i  in  ADDR_WIDTH  AR address
arvalid_i  in  1  AR valid
arready_o  out  1  AR ready
awid_i  in  ID_WIDTH  AW ID
awaddr_i  in  ADDR_WIDTH  AW address
awvalid_i  in  1  AW valid
awready_o  out  1  AW ready
index_o  out  INDEX_BITS  set index of the entry held in the output register
fifo_afull_i  in  1  FIFO almost full
fifo_write_en_o  out  1  FIFO push strobe
fifo_data_o  out  ENTRY_W  entry: [0] is_write, [ID_WIDTH:1] id, [ENTRY_W-1:ID_WIDTH+1] full address
rd_cnt_o  out  CNT_WIDTH  accepted AR count, saturating
wr_cnt_o  out  CNT_WIDTH  accepted AW count, saturating

Behaviour:
- Reset (rst_n=0 at posedge clk): out_valid=0, fifo_data_o=0, index_o=0, last_grant=AW (so the first tie goes to AR), counters=0.
- Reset output values: arready_o=0, awready_o=0, fifo_write_en_o=0.
- Reset mid-operation: a held entry is discarded and no push occurs.
- Storage: one output register plus out_valid. State machine states: EMPTY (out_valid=0) and FULL (out_valid=1).
- push = out_valid & !fifo_afull_i (combinational). fifo_write_en_o = push; it is high for exactly one cycle per entry.
- can_accept = !out_valid | push. Back-to-back acceptance gives 1 request/cycle while the FIFO is not almost full.
- Grant (combinational):
  - Only one of arvalid_i/awvalid_i high: grant it.
  - Both high, PRIO_MODE=0: grant the channel opposite last_grant.
  - Both high, PRIO_MODE=1: grant AR.
- arready_o = can_accept & grant_ar; awready_o = can_accept & grant_aw. At most one ready is high per cycle. Ready is never high when the FIFO is almost full and the register is occupied.
- On handshake (valid&ready), the next-cycle register loads:
  - is_write (0 for AR, 1 for AW), id and full address from the granted channel;
  - index_o = addr[INDEX_LSB +: INDEX_BITS];
  - out_valid=1; last_grant = granted channel.
- Push with no handshake: out_valid returns to 0. fifo_data_o and index_o hold their last values.
- Push and handshake in the same cycle: the register reloads and out_valid stays 1.
- Latency: handshake at cycle N -> earliest fifo_write_en_o at N+1. While fifo_afull_i=1 the entry is held stable; fifo_data_o does not change while out_valid & fifo_afull_i.
- Counters: increment by 1 on each AR/AW handshake. They saturate at all-ones and do not wrap.
- AXI rules: valid may be asserted independently of ready. The block never drops or duplicates a request. A valid request that has not been granted stays pending because ready is low.

Test Plan:
- Single read: araddr_i=0x0000_0000_0000_1A40, arid_i=0x0005, arvalid 1 cycle with ready=1 -> next cycle fifo_write_en_o=1, index_o=0x9, fifo_data_o={addr,0x0005,0}; rd_cnt_o=1.
- Simultaneous AR/AW, PRIO_MODE=0, both held valid for 4 cycles:
  - grants alternate AR, AW, AR, AW;
  - pushes carry is_write 0,1,0,1 on consecutive cycles;
  - both counters end at 2.
- PRIO_MODE=1 with both valid 3 cycles -> only arready_o pulses, 3 reads pushed, awready_o stays 0 until arvalid_i drops.
- Back-pressure: one AW accepted, then fifo_afull_i=1 for 5 cycles:
  - fifo_write_en_o stays 0 and fifo_data_o is stable;
  - ready is low while another request is pending;
  - fifo_afull_i=0 -> push in the same cycle and the pending request is accepted in that same cycle.
- Reset mid-operation: an entry is held under fifo_afull_i=1, then rst_n=0 for 1 cycle -> no push follows, counters=0, first grant after a tie is AR.
- Counter saturation (CNT_WIDTH=3): 9 reads -> rd_cnt_o stays 7 and does not wrap to 0.
